ifu_fetch_ctrl: RTL and testbench

Instruction fetch controller for the rvseed core; it is the producer side of the IFU-to-IDU interface. It owns the PC, issues requests to instruction memory over a req/gnt/rvalid handshake, and returns each instruction with its PC plus single-cycle start and done strobes to the decode stage. It supports redirection (branch/jump) from later stages and a decode stall.

---
 rtl/ifu_fetch_ctrl_pkg.sv | 25 ++
 rtl/ifu_fetch_ctrl_pc_gen.sv | 47 ++++
 rtl/ifu_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_ctrl_pkg
//  Purpose  : Shared constants and FSM encoding for the rvseed IFU fetch path.
//  Revision : 1.0  initial release
// ============================================================================
package ifu_fetch_ctrl_pkg;

    localparam int          IFU_CPU_WIDTH = 32;
    localparam logic [31:0] IFU_NOP_INST  = 32'h0000_0013;
    localparam int          IFU_PC_INCR   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifu_state_e;

    // A new fetch may start only while the core is enabled and decode can accept.
    function automatic logic ifu_can_fetch(input logic enable, input logic idu_stall);
        return enable & ~idu_stall;
    endfunction

endpackage : ifu_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_pc_gen
//  Purpose  : Fetch PC register with redirect / +4 / hold selection.
//  Revision : 1.0  initial release
// ============================================================================
module ifu_pc_gen
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int                   CPU_WIDTH = IFU_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_en_i,
    input  logic [CPU_WIDTH-1:0] redirect_pc_i,
    input  logic                 advance_i,
    output logic [CPU_WIDTH-1:0] pc_o
);

    localparam logic [CPU_WIDTH-1:0] ALIGN_MASK = {{(CPU_WIDTH-2){1'b1}}, 2'b00};

    logic [CPU_WIDTH-1:0] pc_q;
    logic [CPU_WIDTH-1:0] pc_d;

    // Redirect wins over the sequential increment; the adder wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (redirect_en_i) begin
            pc_d = redirect_pc_i & ALIGN_MASK;
        end else if (advance_i) begin
            pc_d = pc_q + CPU_WIDTH'(IFU_PC_INCR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : ifu_pc_gen
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_ctrl
//  Purpose  : rvseed instruction fetch controller (imem req/gnt/rvalid to IDU).
//             Optional macro IFU_FETCH_CNT_EN adds the ifu_fetch_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int                   CPU_WIDTH = IFU_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [CPU_WIDTH-1:0] NOP_INST  = CPU_WIDTH'(IFU_NOP_INST)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 idu_stall,
    input  logic                 redirect_en,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic                 ifu_start_en,
    output logic                 ifu_done_en,
    output logic [CPU_WIDTH-1:0] ifu_inst_pc,
    output logic [CPU_WIDTH-1:0] ifu_inst
`ifdef IFU_FETCH_CNT_EN
    ,
    output logic [31:0]          ifu_fetch_cnt
`endif
);

    ifu_state_e           state_q;
    ifu_state_e           state_d;
    logic                 drop_q;
    logic                 drop_d;
    logic                 start_q;
    logic                 start_d;
    logic                 done_q;
    logic [CPU_WIDTH-1:0] inst_q;
    logic [CPU_WIDTH-1:0] inst_pc_q;
    logic [CPU_WIDTH-1:0] w_pc;
    logic                 w_go;
    logic                 w_capture;

    assign w_go = ifu_can_fetch(enable, idu_stall);

    ifu_pc_gen #(
        .CPU_WIDTH (CPU_WIDTH),
        .RESET_PC  (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_en_i (redirect_en),
        .redirect_pc_i (redirect_pc),
        .advance_i     (w_capture),
        .pc_o          (w_pc)
    );

    // A redirect that lands after the request is committed to memory cannot
    // cancel it, so the drop flag swallows the matching response instead.
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        w_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_go) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                    if (redirect_en) begin
                        drop_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    drop_d    = 1'b0;
                    w_capture = ~drop_q & ~redirect_en;
                    state_d   = w_go ? REQ : IDLE;
                end else if (redirect_en) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
        endcase
        start_d = (state_d == REQ) && (state_q != REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            start_q <= start_d;
            done_q  <= w_capture;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q    <= NOP_INST;
            inst_pc_q <= '0;
        end else if (w_capture) begin
            inst_q    <= imem_rdata;
            inst_pc_q <= w_pc;
        end
    end

`ifdef IFU_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Counts alongside done so the value is current in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
        end else if (w_capture) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign ifu_fetch_cnt = fetch_cnt_q;
`endif

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = w_pc;
    assign ifu_start_en = start_q;
    assign ifu_done_en  = done_q;
    assign ifu_inst     = inst_q;
    assign ifu_inst_pc  = inst_pc_q;

endmodule : ifu_fetch_ctrl
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu_fetch_ctrl
//  Purpose  : Self-checking bench for ifu_fetch_ctrl (directed + random).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        idu_stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifu_start_en;
    logic        ifu_done_en;
    logic [31:0] ifu_inst_pc;
    logic [31:0] ifu_inst;
`ifdef IFU_FETCH_CNT_EN
    logic [31:0] ifu_fetch_cnt;
`endif

    ifu_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .idu_stall    (idu_stall),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .ifu_start_en (ifu_start_en),
        .ifu_done_en  (ifu_done_en),
        .ifu_inst_pc  (ifu_inst_pc),
        .ifu_inst     (ifu_inst)
`ifdef IFU_FETCH_CNT_EN
        ,
        .ifu_fetch_cnt(ifu_fetch_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // Transaction-level expectation: is a request on the bus, is a response
    // owed, should that response be discarded, and what was last delivered.
    typedef struct {
        bit          on_bus;
        bit          owed;
        bit          discard;
        bit          start;
        bit          done;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] inst_pc;
        logic [31:0] cnt;
    } mdl_t;

    mdl_t m;
    mdl_t n;
    int   n_pass = 0;
    int   n_tot  = 0;
    bit   chk_en = 1'b0;

    function automatic mdl_t reset_val();
        mdl_t r;
        r.on_bus  = 1'b0;
        r.owed    = 1'b0;
        r.discard = 1'b0;
        r.start   = 1'b0;
        r.done    = 1'b0;
        r.pc      = RESET_PC;
        r.inst    = NOP_INST;
        r.inst_pc = 32'h0;
        r.cnt     = 32'h0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void model_next();
        bit go;
        go      = enable && !idu_stall;
        n       = m;
        n.start = 1'b0;
        n.done  = 1'b0;
        if (!rst_n) begin
            n = reset_val();
            return;
        end
        if (redirect_en) n.pc = {redirect_pc[31:2], 2'b00};
        if (m.on_bus) begin
            if (imem_gnt) begin
                n.on_bus  = 1'b0;
                n.owed    = 1'b1;
                n.discard = redirect_en;
            end
        end else if (m.owed) begin
            if (imem_rvalid) begin
                n.owed    = 1'b0;
                n.discard = 1'b0;
                if (!m.discard && !redirect_en) begin
                    n.done    = 1'b1;
                    n.inst    = imem_rdata;
                    n.inst_pc = m.pc;
                    n.pc      = m.pc + 32'd4;
                    n.cnt     = m.cnt + 32'd1;
                end
                if (go) begin
                    n.on_bus = 1'b1;
                    n.start  = 1'b1;
                end
            end else if (redirect_en) begin
                n.discard = 1'b1;
            end
        end else if (go) begin
            n.on_bus = 1'b1;
            n.start  = 1'b1;
        end
    endfunction

    // Called at posedge+1: drive one cycle of inputs, advance the model.
    task automatic step(input bit en, input bit st, input bit rd, input logic [31:0] rpc,
                        input bit g, input bit rv, input logic [31:0] rdat);
        enable      = en;
        idu_stall   = st;
        redirect_en = rd;
        redirect_pc = rpc;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rdat;
        model_next();
        @(posedge clk);
        m = n;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", 32'(imem_req), 32'(m.on_bus));
            if (m.on_bus || !rst_n) chk("imem_addr", imem_addr, m.pc);
            chk("start_en", 32'(ifu_start_en), 32'(m.start));
            chk("done_en", 32'(ifu_done_en), 32'(m.done));
            chk("inst", ifu_inst, m.inst);
            chk("inst_pc", ifu_inst_pc, m.inst_pc);
`ifdef IFU_FETCH_CNT_EN
            chk("fetch_cnt", ifu_fetch_cnt, m.cnt);
`endif
        end
    end

    initial begin
        rst_n = 1'b1; enable = 1'b0; idu_stall = 1'b0; redirect_en = 1'b0;
        redirect_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        m = reset_val();
        #3;
        rst_n = 1'b0;
        m = reset_val();
        step(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_inst", ifu_inst, 32'h0000_0013);
        chk("rst_req", 32'(imem_req), 32'h0);
        rst_n = 1'b1;

        // First fetch: gnt immediate, rvalid next cycle
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t1_start", 32'(ifu_start_en), 32'h1);
        chk("t1_addr", imem_addr, 32'h0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h0050_0093);
        chk("t1_done", 32'(ifu_done_en), 32'h1);
        chk("t1_inst", ifu_inst, 32'h0050_0093);
        chk("t1_inst_pc", ifu_inst_pc, 32'h0);
        chk("t1_next_addr", imem_addr, 32'h4);

        // Grant held off for three cycles at 0x8
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            chk("t2_hold_addr", imem_addr, 32'h8);
            chk("t2_hold_start", 32'(ifu_start_en), 32'h0);
        end
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h2222_2222);
        chk("t2_inst_pc", ifu_inst_pc, 32'h8);

        // Redirect while waiting for 0xC drops that response
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 32'h0000_0103, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h3333_3333);
        chk("t3_no_done", 32'(ifu_done_en), 32'h0);
        chk("t3_inst_kept", ifu_inst, 32'h2222_2222);
        chk("t3_redir_addr", imem_addr, 32'h100);

        // Stall at response completion
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 1, 32'h4444_4444);
        chk("t4_done", 32'(ifu_done_en), 32'h1);
        chk("t4_idle", 32'(imem_req), 32'h0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t4_resume_addr", imem_addr, 32'h104);

        // Redirect before grant to the top word, then wrap
        step(1, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
        chk("t5_addr_switch", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h5555_5555);
        chk("t5_inst_pc", ifu_inst_pc, 32'hFFFF_FFFC);
        chk("t5_wrap_addr", imem_addr, 32'h0);
`ifdef IFU_FETCH_CNT_EN
        chk("t5_cnt", ifu_fetch_cnt, 32'd5);
`endif

        // Reset during WAIT, then a late rvalid
        step(1, 0, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        m = reset_val();
        #1;
        chk("t6_rst_inst", ifu_inst, 32'h0000_0013);
        chk("t6_rst_addr", imem_addr, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 1, 32'h6666_6666);
        chk("t6_late_done", 32'(ifu_done_en), 32'h0);
        chk("t6_late_inst", ifu_inst, 32'h0000_0013);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t6_first_addr", imem_addr, 32'h0);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            bit          en;
            bit          st;
            bit          rd;
            bit          g;
            bit          rv;
            logic [31:0] rpc;
            en  = ($urandom_range(0, 9) < 8);
            st  = ($urandom_range(0, 9) < 2);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            g   = m.on_bus && ($urandom_range(0, 1) == 1);
            rv  = m.owed ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                m = reset_val();
                step(en, st, rd, rpc, g, rv, $urandom);
                rst_n = 1'b1;
            end else begin
                step(en, st, rd, rpc, g, rv, $urandom);
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_ifu_fetch_ctrl
`default_nettype wire
